// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - MDU opcode encodings and default latencies
//
// Purpose: shared definitions for the multiply/divide unit.
//   md_op_e            : decoded MDU opcode carried into the E stage
//   MD_*_CYCLES_DEF    : default busy-cycle counts for mult and div
//   MD_CNT_W           : width of the busy counter (covers 1..15 cycles)
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
    localparam int unsigned MD_CNT_W           = 4;

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational MIPS multiply/divide result generator
//
// Purpose: produces the 64-bit {hi,lo} result of mult/multu/div/divu.
// Ports:
//   i_md_op  [3:0]  : MDU opcode
//   i_md_a   [31:0] : rs operand (dividend / multiplicand)
//   i_md_b   [31:0] : rt operand (divisor / multiplier)
//   o_res_hi [31:0] : product high word, or remainder
//   o_res_lo [31:0] : product low word, or quotient
//   o_div0          : div/divu with a zero divisor
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  i_md_op,
    input  logic [31:0] i_md_a,
    input  logic [31:0] i_md_b,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_b_zero;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Sign-extending to 64 bits and keeping the low 64 bits of the
    // product gives the exact two's-complement signed product.
    assign w_prod_s = {{32{i_md_a[31]}}, i_md_a} * {{32{i_md_b[31]}}, i_md_b};
    assign w_prod_u = {32'd0, i_md_a} * {32'd0, i_md_b};

    // Signed divide is done on magnitudes and the signs restored after:
    // quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign w_b_zero     = (i_md_b == 32'd0);
    assign w_div_signed = (i_md_op == MD_DIV);
    assign w_a_neg      = w_div_signed & i_md_a[31];
    assign w_b_neg      = w_div_signed & i_md_b[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - i_md_a) : i_md_a;
    // Divisor forced to 1 on zero so the divider never sees x/0; the
    // result is discarded by the controller anyway.
    assign w_b_mag      = w_b_zero ? 32'd1 : (w_b_neg ? (32'd0 - i_md_b) : i_md_b);
    assign w_q_mag      = w_a_mag / w_b_mag;
    assign w_r_mag      = w_a_mag % w_b_mag;
    assign w_q          = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r          = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_res_hi = 32'd0;
        o_res_lo = 32'd0;
        o_div0   = 1'b0;
        case (i_md_op)
            MD_MULT:  {o_res_hi, o_res_lo} = w_prod_s;
            MD_MULTU: {o_res_hi, o_res_lo} = w_prod_u;
            MD_DIV, MD_DIVU: begin
                o_res_hi = w_r;
                o_res_lo = w_q;
                o_div0   = w_b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MIPS E-stage multiply/divide unit with HI/LO and stall control
//
// Purpose: sequences mult/div latency with a busy counter, owns HI/LO,
// serves mfhi/mflo and raises the D-stage stall for MDU instructions.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   md_op    [3:0]    : E-stage MDU opcode (MD_NONE if not MDU)
//   md_a, md_b [31:0] : forwarded rs / rt in E
//   D_md_use          : D-stage instruction is an MDU instruction
//   md_busy           : mult/div in flight
//   md_stall          : stall request to the hazard unit
//   md_rdata [31:0]   : mfhi/mflo read data
//   hi, lo   [31:0]   : architectural HI / LO
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic        D_md_use,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [MD_CNT_W-1:0] r_cnt;
    logic [31:0]         r_res_hi;
    logic [31:0]         r_res_lo;
    logic                r_div0;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    logic [31:0]         w_res_hi;
    logic [31:0]         w_res_lo;
    logic                w_div0;
    logic                w_busy;
    logic                w_is_mul;
    logic                w_is_div;
    logic                w_start;

    mdu_calc u_calc (
        .i_md_op  (md_op),
        .i_md_a   (md_a),
        .i_md_b   (md_b),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo),
        .o_div0   (w_div0)
    );

    assign w_busy   = (r_cnt != '0);
    assign w_is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign w_is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    // Any MDU op arriving while busy is dropped; the hazard stall is
    // what keeps that from happening in a well-formed pipeline.
    assign w_start  = (w_is_mul || w_is_div) && !w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_div0   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (w_start) begin
            r_cnt    <= w_is_mul ? MD_CNT_W'(MULT_CYCLES) : MD_CNT_W'(DIV_CYCLES);
            r_res_hi <= w_res_hi;
            r_res_lo <= w_res_lo;
            r_div0   <= w_div0;
        end else if (w_busy) begin
            r_cnt <= r_cnt - 1'b1;
            // Commit on the 1->0 edge so HI/LO and busy change together.
            if (r_cnt == MD_CNT_W'(1) && !r_div0) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end else if (md_op == MD_MTHI) begin
            r_hi <= md_a;
        end else if (md_op == MD_MTLO) begin
            r_lo <= md_a;
        end
    end

    always_comb begin
        md_rdata = 32'd0;
        case (md_op)
            MD_MFHI: md_rdata = r_hi;
            MD_MFLO: md_rdata = r_lo;
            default: ;
        endcase
    end

    assign md_busy  = w_busy;
    assign md_stall = D_md_use & (w_start | w_busy);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        D_md_use;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    int viol_cnt = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .D_md_use (D_md_use),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .md_rdata (md_rdata),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Protocol monitor: an MDU op in E while busy must never happen in a
    // correctly stalled pipeline; tally every occurrence.
    always @(negedge clk) begin
        if (!reset && md_busy && md_op != 4'(MD_NONE)) viol_cnt <= viol_cnt + 1;
    end

    // Inputs change just after the rising edge; outputs are sampled on
    // the falling edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; md_op = 4'(MD_NONE); md_a = '0; md_b = '0; D_md_use = 1'b0;
        to_drive();
        to_drive();
        reset = 1'b0;
        to_drive();
        to_sample();
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", md_stall); end
        checks++; if (md_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", md_rdata, 32'd0); end
    endtask

    // Issues one mult/div with D_md_use held and checks the full busy window.
    task automatic test_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int n, input logic [31:0] old_hi, input logic [31:0] old_lo,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        to_drive();
        md_op = op; md_a = a; md_b = b; D_md_use = 1'b1;
        to_sample();
        checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL start_stall op=%0d got=%b exp=1", op, md_stall); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL start_busy op=%0d got=%b exp=0", op, md_busy); end
        for (int i = 1; i <= n; i++) begin
            to_drive();
            md_op = 4'(MD_NONE);
            to_sample();
            checks++; if (md_busy !== 1'b1 || md_stall !== 1'b1) begin errors++; $display("FAIL busy_window op=%0d cyc=%0d busy=%b stall=%b exp=1,1", op, i, md_busy, md_stall); end
            checks++; if (hi !== old_hi || lo !== old_lo) begin errors++; $display("FAIL hold_hilo op=%0d cyc=%0d got=%h_%h exp=%h_%h", op, i, hi, lo, old_hi, old_lo); end
        end
        to_drive();
        to_sample();
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL done_hi op=%0d got=%h exp=%h", op, hi, exp_hi); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL done_lo op=%0d got=%h exp=%h", op, lo, exp_lo); end
        checks++; if (md_busy !== 1'b0 || md_stall !== 1'b0) begin errors++; $display("FAIL done_idle op=%0d busy=%b stall=%b exp=0,0", op, md_busy, md_stall); end
        D_md_use = 1'b0;
    endtask

    task automatic test_mthi_mfhi();
        to_drive();
        md_op = 4'(MD_MTHI); md_a = 32'h1234_5678; D_md_use = 1'b0;
        to_sample();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", md_busy); end
        to_drive();
        md_op = 4'(MD_MFHI); md_a = 32'h0;
        to_sample();
        checks++; if (md_rdata !== 32'h1234_5678) begin errors++; $display("FAIL mfhi_rdata got=%h exp=%h", md_rdata, 32'h1234_5678); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL mfhi_busy got=%b exp=0", md_busy); end
        to_drive();
        md_op = 4'(MD_MFLO);
        to_sample();
        checks++; if (md_rdata !== 32'd3) begin errors++; $display("FAIL mflo_rdata got=%h exp=%h", md_rdata, 32'd3); end
        md_op = 4'(MD_NONE);
    endtask

    task automatic test_reset_abort();
        to_drive();
        md_op = 4'(MD_MULT); md_a = 32'd3; md_b = 32'd4; D_md_use = 1'b0;
        to_drive();
        md_op = 4'(MD_NONE);
        to_drive();
        to_drive();
        reset = 1'b1;
        to_sample();
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL abort_prebusy got=%b exp=1", md_busy); end
        to_drive();
        reset = 1'b0;
        to_sample();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", md_busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_hilo got=%h_%h exp=0_0", hi, lo); end
        for (int i = 0; i < 6; i++) begin
            to_drive();
            to_sample();
        end
        checks++; if (hi !== 32'd0 || lo !== 32'd0 || md_busy !== 1'b0) begin errors++; $display("FAIL abort_late got=%h_%h busy=%b exp=0_0 busy=0", hi, lo, md_busy); end
    endtask

    task automatic test_back_to_back();
        to_drive();
        md_op = 4'(MD_MULT); md_a = 32'd6; md_b = 32'd7; D_md_use = 1'b1;
        to_drive();
        md_op = 4'(MD_NONE);
        to_drive();
        md_op = 4'(MD_MTLO); md_a = 32'hDEAD_BEEF;
        to_sample();
        checks++; if (md_busy !== 1'b1 || lo !== 32'd0) begin errors++; $display("FAIL viol_busy busy=%b lo=%h exp=1 lo=0", md_busy, lo); end
        for (int i = 0; i < 3; i++) begin
            to_drive();
            md_op = 4'(MD_NONE);
        end
        to_drive();
        md_op = 4'(MD_MULT); md_a = 32'd2; md_b = 32'd5;
        to_sample();
        checks++; if (md_busy !== 1'b0 || md_stall !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b stall=%b exp=0,1", md_busy, md_stall); end
        checks++; if (lo !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL viol_result got=%h_%h exp=%h_%h", hi, lo, 32'd0, 32'd42); end
        checks++; if (md_rdata !== 32'd0) begin errors++; $display("FAIL rdata_nonmf got=%h exp=0", md_rdata); end
        to_drive();
        md_op = 4'(MD_NONE);
        to_sample();
        checks++; if (md_busy !== 1'b1 || lo !== 32'd42) begin errors++; $display("FAIL b2b_busy busy=%b lo=%h exp=1 lo=%h", md_busy, lo, 32'd42); end
        for (int i = 0; i < 4; i++) begin
            to_drive();
        end
        to_drive();
        md_op = 4'(MD_MFLO); D_md_use = 1'b0;
        to_sample();
        checks++; if (md_busy !== 1'b0 || md_rdata !== 32'd10) begin errors++; $display("FAIL b2b_mflo busy=%b rdata=%h exp=0 rdata=%h", md_busy, md_rdata, 32'd10); end
        md_op = 4'(MD_NONE);
        checks++; if (viol_cnt !== 1) begin errors++; $display("FAIL protocol_monitor got=%0d exp=1", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_muldiv(4'(MD_MULT),  32'hFFFF_FFFE, 32'd3, 5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        test_muldiv(4'(MD_MULTU), 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
        test_muldiv(4'(MD_DIV),   32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_muldiv(4'(MD_DIVU),  32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
        test_mthi_mfhi();
        test_muldiv(4'(MD_DIVU),  32'd5, 32'd0, 10, 32'h1234_5678, 32'd3, 32'h1234_5678, 32'd3);
        test_muldiv(4'(MD_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h1234_5678, 32'd3, 32'd0, 32'h8000_0000);
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit with sequencing control, sitting beside the ALU in the E stage of the five-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E.
- Models the multi-cycle latency of mult/div with a busy counter, and owns the HI/LO registers.
- Drives the stall request the hazard unit uses to freeze an MDU instruction in D while E holds or runs an MDU operation.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- md_op  input  4  decoded MDU opcode of the E-stage instruction (MD_NONE when not an MDU op)
- md_a  input  32  forwarded rs value in E
- md_b  input  32  forwarded rt value in E
- D_md_use  input  1  the D-stage instruction is any MDU instruction
- md_busy  output  1  a mult/div is in flight
- md_stall  output  1  stall request to the hazard unit
- md_rdata  output  32  mfhi/mflo read data for the E-stage result mux
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, counter=0, md_busy=0, shadow result registers=0. Reset mid-operation aborts the operation; HI/LO stay 0.
- start = md_op in {MULT, MULTU, DIV, DIVU} and !md_busy.
- On the start edge:
  - Compute the result combinationally from md_a/md_b and latch it into shadow regs res_hi/res_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- md_busy = (counter != 0), registered.
- Each edge with counter != 0 decrements the counter. On the edge where counter goes 1->0, hi<=res_hi and lo<=res_lo.
- Timing: start sampled at edge t. md_busy=1 during cycles t+1..t+N. New HI/LO are visible in cycle t+N+1, the same cycle md_busy drops.
- Arithmetic:
  - mult: signed 64-bit product. multu: unsigned 64-bit product. {hi,lo} = product.
  - div: signed; quotient truncates toward zero; remainder takes the dividend's sign. lo=quotient, hi=remainder.
  - divu: unsigned.
  - Divide by zero (div/divu with md_b=0): counter still runs, HI/LO left unchanged at completion.
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO with !md_busy: hi (or lo) <= md_a at the next edge. No busy cycles.
- MFHI/MFLO: md_rdata = hi or lo, combinational. For any other op, md_rdata=0.
- md_stall = D_md_use & (start | md_busy), combinational. This guarantees no MDU op reaches E while busy.
- Protocol violation (any MDU op other than MD_NONE in E while md_busy): ignored. The busy operation and HI/LO are unaffected. A bench assertion flags it.
- Back-to-back: a new start is accepted in the first cycle md_busy=0; mfhi in that cycle reads the new value.
- Simultaneous completion and MTHI in E: cannot occur, because the op is ignored while busy.

Decomposition:
- Shared macros file:
  - md_op encodings: MD_NONE=0, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO.
  - Default cycle counts.
- The CU gains the md_op output and the D_md_use decode. It reuses the existing instruction field macros.
- One natural sub-module: mdu_calc, combinational. Inputs md_op, md_a, md_b. Outputs res_hi, res_lo, div0 flag.
- mdu_ctrl holds the counter, shadow registers, HI/LO and stall logic.

Test Plan:
1. reset=1 for 2 cycles, then idle. Expect hi=lo=0, md_busy=0, md_stall=0, md_rdata=0.
2. MULT with a=0xFFFFFFFE (-2), b=3, D_md_use=1 held.
   - Cycle t: md_stall=1.
   - Cycles t+1..t+5: md_busy=1, md_stall=1, hi/lo still old.
   - Cycle t+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, md_busy=0, md_stall=0.
   - Same inputs as MULTU: hi=0x00000002, lo=0xFFFFFFFA.
3. DIV a=-7 (0xFFFFFFF9), b=2. After 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=7, b=2: lo=3, hi=1.
4. MTHI a=0x12345678 then MFHI next cycle: md_rdata=0x12345678, md_busy never asserts. Then DIVU b=0: after 10 cycles hi/lo unchanged. Then div 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
5. MULT started, reset asserted in busy cycle 3. Next cycle: md_busy=0, hi=lo=0, and no later HI/LO update occurs.
6. MULT, then an MTLO presented during busy (protocol violation): lo ends with the product. MULT issued in the cycle md_busy falls: accepted, md_busy high again the next cycle.
